adc_serdes_tx: RTL and testbench



---
 rtl/adc_serdes_tx.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_adc_serdes_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serdes_tx.sv
// adc_serdes_tx
//
// Bit-serial transmitter that emulates the ADC LVDS output: eight data lanes
// plus a frame clock, framed with pattern 8'h0f and sent MSB first. It serves
// as a loopback and bench source for the capture path. Sample words enter a
// small FIFO through a valid/ready handshake. After leaving IDLE the block
// waits an optional bit delay and sends a training sequence. It then
// serializes one FIFO word per frame.
//
// Ports
//   clk            bit clock, one serial bit per cycle per lane
//   rst_n          asynchronous active-low reset
//   enable_i       start/stop transmission (stop completes the current frame)
//   frame_phase_i  bit delay before the first frame, latched when leaving IDLE
//   s_data_i       64-bit sample word, lane i = s_data_i[8i+7:8i]
//   s_valid_i      s_data_i valid
//   s_ready_o      FIFO not full (registered)
//   ser_data_o     serial data, one bit per lane
//   ser_fclk_o     serial frame clock, 0000_1111 per frame
//   frame_start_o  high during bit 0 of every frame
//   training_o     high while training frames are on the wire
//   underrun_o     sticky, RUN needed a word and the FIFO was empty
//   frame_count_o  live (RUN) frames sent, wraps
//
// Optional feature, macro ADC_SERDES_TX_RAMP_EN:
//   adds ramp_mode_i. While it is high at a RUN frame load, lane i sends
//   (ramp + i) mod 256 instead of a FIFO word. The ramp restarts at 0 on RUN
//   entry.
//
// State table
//   state    | meaning
//   ST_IDLE  | outputs 0, waiting for enable_i
//   ST_PHASE | outputs 0 for the latched frame_phase cycles
//   ST_TRAIN | sending TRAIN_FRAMES frames of TRAIN_WORD, training_o=1
//   ST_RUN   | sending FIFO words (IDLE_WORD and underrun on empty)

module adc_serdes_tx #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned TRAIN_FRAMES = 16,
    parameter logic [7:0]  TRAIN_WORD   = 8'hA5,
    parameter logic [7:0]  IDLE_WORD    = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [2:0]  frame_phase_i,
    input  logic [63:0] s_data_i,
    input  logic        s_valid_i,
`ifdef ADC_SERDES_TX_RAMP_EN
    input  logic        ramp_mode_i,
`endif
    output logic        s_ready_o,
    output logic [7:0]  ser_data_o,
    output logic        ser_fclk_o,
    output logic        frame_start_o,
    output logic        training_o,
    output logic        underrun_o,
    output logic [15:0] frame_count_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_TRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    phase_cnt_q, phase_cnt_d;
    logic [7:0]    train_cnt_q, train_cnt_d;
    logic [63:0]   shreg_q, shreg_d;
    logic [7:0]    ser_data_q, ser_data_d;
    logic          fclk_q, fclk_d;
    logic          fstart_q, fstart_d;
    logic          training_q, training_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          s_ready_q;
    logic          push, pop;

    logic          load, run_load, active;
    logic [63:0]   load_word;

`ifdef ADC_SERDES_TX_RAMP_EN
    logic [7:0]    ramp_q, ramp_d;
    logic [7:0]    ramp_val;
`endif

    // ------------------------------------------------------------------
    // FIFO: pops happen only at RUN frame loads. The read word comes from
    // the registered head, so a push in the load cycle is not visible.
    // ------------------------------------------------------------------
    assign push = s_valid_i & s_ready_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            s_ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Sequencer and serializer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        phase_cnt_d = phase_cnt_q;
        train_cnt_d = train_cnt_q;
        shreg_d     = shreg_q;
        ser_data_d  = '0;
        fclk_d      = 1'b0;
        fstart_d    = 1'b0;
        training_d  = 1'b0;
        underrun_d  = underrun_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;
        run_load    = 1'b0;
        load_word   = '0;
        pop         = 1'b0;
`ifdef ADC_SERDES_TX_RAMP_EN
        ramp_d      = ramp_q;
        ramp_val    = ramp_q;
`endif
        // Mid-frame bits are shifted out; bit 7 is always followed by a load or by IDLE.
        active = ((state_q == ST_TRAIN) || (state_q == ST_RUN)) && (bit_q != 3'd7);

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    underrun_d = 1'b0;
                    if (frame_phase_i == 3'd0) begin
                        // Zero delay: the first training frame loads on this edge.
                        load        = 1'b1;
                        load_word   = {8{TRAIN_WORD}};
                        train_cnt_d = 8'(TRAIN_FRAMES - 1);
                        state_d     = ST_TRAIN;
                    end else begin
                        phase_cnt_d = frame_phase_i;
                        state_d     = ST_PHASE;
                    end
                end
            end
            ST_PHASE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (phase_cnt_q == 3'd1) begin
                    load        = 1'b1;
                    load_word   = {8{TRAIN_WORD}};
                    train_cnt_d = 8'(TRAIN_FRAMES - 1);
                    state_d     = ST_TRAIN;
                end else begin
                    phase_cnt_d = phase_cnt_q - 3'd1;
                end
            end
            ST_TRAIN: begin
                if (bit_q == 3'd7) begin
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (train_cnt_q == 8'd0) begin
                        run_load = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        load        = 1'b1;
                        load_word   = {8{TRAIN_WORD}};
                        train_cnt_d = train_cnt_q - 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (bit_q == 3'd7) begin
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        run_load = 1'b1;
                    end
                end
            end
        endcase

        if (run_load) begin
            load        = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef ADC_SERDES_TX_RAMP_EN
            // The ramp restarts on the TRAIN->RUN load.
            ramp_val = (state_q == ST_TRAIN) ? 8'd0 : ramp_q;
            ramp_d   = ramp_val + 8'd1;
            if (ramp_mode_i) begin
                for (int i = 0; i < 8; i++) begin
                    load_word[8*i +: 8] = ramp_val + 8'(i);
                end
            end else
`endif
            if (count_q != '0) begin
                pop       = 1'b1;
                load_word = mem_q[rd_ptr_q];
            end else begin
                load_word  = {8{IDLE_WORD}};
                underrun_d = 1'b1;
            end
        end

        if (load) begin
            bit_d = 3'd0;
            for (int i = 0; i < 8; i++) begin
                ser_data_d[i]       = load_word[8*i+7];
                shreg_d[8*i +: 8]   = {load_word[8*i +: 7], 1'b0};
            end
        end else if (active) begin
            bit_d = bit_q + 3'd1;
            for (int i = 0; i < 8; i++) begin
                ser_data_d[i]       = shreg_q[8*i+7];
                shreg_d[8*i +: 8]   = {shreg_q[8*i +: 7], 1'b0};
            end
        end else begin
            bit_d = 3'd0;
        end

        // Frame clock is high for bits 4..7, i.e. bit index MSB.
        fclk_d     = (load || active) ? bit_d[2] : 1'b0;
        fstart_d   = load;
        training_d = (state_d == ST_TRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            phase_cnt_q <= '0;
            train_cnt_q <= '0;
            shreg_q     <= '0;
            ser_data_q  <= '0;
            fclk_q      <= 1'b0;
            fstart_q    <= 1'b0;
            training_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
`ifdef ADC_SERDES_TX_RAMP_EN
            ramp_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            phase_cnt_q <= phase_cnt_d;
            train_cnt_q <= train_cnt_d;
            shreg_q     <= shreg_d;
            ser_data_q  <= ser_data_d;
            fclk_q      <= fclk_d;
            fstart_q    <= fstart_d;
            training_q  <= training_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef ADC_SERDES_TX_RAMP_EN
            ramp_q      <= ramp_d;
`endif
        end
    end

    assign s_ready_o     = s_ready_q;
    assign ser_data_o    = ser_data_q;
    assign ser_fclk_o    = fclk_q;
    assign frame_start_o = fstart_q;
    assign training_o    = training_q;
    assign underrun_o    = underrun_q;
    assign frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_adc_serdes_tx.sv
// Testbench for adc_serdes_tx: scoreboard of accepted words, frame-level
// reference model in the monitor, random words and frame phases.

module tb_adc_serdes_tx;

    localparam int TF    = 16;
    localparam int DEPTH = 4;
    localparam logic [7:0] TRAIN_W = 8'hA5;
    localparam logic [7:0] IDLE_W  = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic [2:0]  frame_phase_i = 3'd0;
    logic [63:0] s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  ser_data_o;
    logic        ser_fclk_o;
    logic        frame_start_o;
    logic        training_o;
    logic        underrun_o;
    logic [15:0] frame_count_o;

    adc_serdes_tx #(
        .FIFO_DEPTH(DEPTH), .TRAIN_FRAMES(TF), .TRAIN_WORD(TRAIN_W), .IDLE_WORD(IDLE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .frame_phase_i(frame_phase_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i),
`ifdef ADC_SERDES_TX_RAMP_EN
        .ramp_mode_i(1'b0),
`endif
        .s_ready_o(s_ready_o), .ser_data_o(ser_data_o), .ser_fclk_o(ser_fclk_o),
        .frame_start_o(frame_start_o), .training_o(training_o), .underrun_o(underrun_o),
        .frame_count_o(frame_count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] w; int stamp; } ent_t;
    ent_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // model / session state shared between stimulus and monitor
    int          leave_edge = 0;
    int          sess_k = 0;
    int          sess_phase = 0;
    bit          rise_seen = 1'b1;
    bit          exp_ur = 1'b0;
    logic [15:0] exp_fc = '0;
    bit          coll = 1'b0;
    int          mb = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + frame-level reference model
    initial begin : monitor
        logic [63:0] got, exp_w;
        bit          exp_train;
        int          L;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                coll = 1'b0;
            end else begin
                if (!rise_seen && ser_fclk_o) begin
                    rise_seen = 1'b1;
                    chk("fclk_first_rise", 64'(cyc - leave_edge), 64'(sess_phase + 4));
                end
                if (frame_start_o) begin
                    if (coll) chk("frame_truncated", 64'(mb), 64'd7);
                    L = cyc;
                    if (sess_k < TF) begin
                        exp_train = 1'b1;
                        exp_w = {8{TRAIN_W}};
                    end else begin
                        exp_train = 1'b0;
                        exp_fc = exp_fc + 16'd1;
                        if (exp_q.size() > 0 && exp_q[0].stamp < L) begin
                            exp_w = exp_q[0].w;
                            void'(exp_q.pop_front());
                        end else begin
                            exp_w = {8{IDLE_W}};
                            exp_ur = 1'b1;
                        end
                    end
                    sess_k++;
                    chk("training", 64'(training_o), 64'(exp_train));
                    chk("frame_count", 64'(frame_count_o), 64'(exp_fc));
                    chk("underrun", 64'(underrun_o), 64'(exp_ur));
                    coll = 1'b1;
                    mb = 0;
                    got = '0;
                end else if (coll) begin
                    mb++;
                end
                if (coll) begin
                    chk("fclk_bit", 64'(ser_fclk_o), 64'(mb >= 4));
                    for (int i = 0; i < 8; i++) got[8*i + 7 - mb] = ser_data_o[i];
                    if (mb == 7) begin
                        chk(exp_train ? "train_word" : "run_word", got, exp_w);
                        coll = 1'b0;
                    end
                end else begin
                    chk("idle_zero", {55'd0, training_o, ser_fclk_o, ser_data_o}, 64'd0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] w, input int budget);
        bit done = 1'b0;
        s_data_i  = w;
        s_valid_i = 1'b1;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (s_ready_o) begin
                exp_q.push_back('{w, cyc + 1});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid_i = 1'b0;
        if (!done) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_session(input int ph);
        enable_i      = 1'b1;
        frame_phase_i = 3'(ph);
        leave_edge    = cyc + 1;
        sess_k        = 0;
        sess_phase    = ph;
        rise_seen     = 1'b0;
        exp_ur        = 1'b0;
    endtask

    // wait until run frame r shows bit b, then return just after the next edge
    task automatic wait_run_bit(input int r, input int b);
        bit hit = 1'b0;
        for (int n = 0; n < 400 && !hit; n++) begin
            @(negedge clk);
            if (coll && mb == b && sess_k == TF + r + 1) hit = 1'b1;
        end
        if (!hit) chk("wait_timeout", 64'(r), 64'hFFFF);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin : stim
        int ph;
        step(2);
        chk("rst_ser_data", 64'(ser_data_o), 64'd0);
        chk("rst_fclk", 64'(ser_fclk_o), 64'd0);
        chk("rst_fstart", 64'(frame_start_o), 64'd0);
        chk("rst_training", 64'(training_o), 64'd0);
        chk("rst_underrun", 64'(underrun_o), 64'd0);
        chk("rst_frame_count", 64'(frame_count_o), 64'd0);
        chk("rst_s_ready", 64'(s_ready_o), 64'd1);
        #3 rst_n = 1'b1;
        step(3);

        // A: phase 0, known word then random words; drop enable at b3 of run frame 1
        start_session(0);
        step(3);
        push_word(64'h0706050403020100, 20);
        push_word(rnd64(), 20);
        push_word(rnd64(), 20);
        wait_run_bit(1, 3);
        enable_i = 1'b0;
        step(15);

        // B: random phase; retained word first, then underrun, then late push
        ph = $urandom_range(1, 7);
        start_session(ph);
        wait_run_bit(1, 3);
        push_word(rnd64(), 4);
        wait_run_bit(2, 3);
        enable_i = 1'b0;
        step(12);

        // C: overfill the FIFO during training
        ph = $urandom_range(0, 7);
        start_session(ph);
        step(2);
        @(negedge clk);
        chk("s_ready_empty", 64'(s_ready_o), 64'(exp_q.size() < DEPTH));
        step(1);
        for (int i = 0; i < DEPTH; i++) push_word(rnd64(), 10);
        @(negedge clk);
        chk("s_ready_full", 64'(s_ready_o), 64'(exp_q.size() < DEPTH));
        step(1);
        push_word(rnd64(), 400);
        wait_run_bit(5, 3);
        enable_i = 1'b0;
        step(12);

        // D: asynchronous reset in the middle of a RUN frame
        start_session(0);
        step(2);
        push_word(rnd64(), 10);
        push_word(rnd64(), 10);
        wait_run_bit(0, 3);
        #2 rst_n = 1'b0;
        enable_i = 1'b0;
        exp_q.delete();
        exp_fc = '0;
        exp_ur = 1'b0;
        #1;
        chk("midrst_ser_data", 64'(ser_data_o), 64'd0);
        chk("midrst_fclk", 64'(ser_fclk_o), 64'd0);
        chk("midrst_frame_count", 64'(frame_count_o), 64'd0);
        chk("midrst_s_ready", 64'(s_ready_o), 64'd1);
        step(2);
        #3 rst_n = 1'b1;
        step(3);

        // E: FIFO must be empty after reset -> first RUN frame underruns
        ph = $urandom_range(0, 7);
        start_session(ph);
        wait_run_bit(0, 3);
        push_word(rnd64(), 4);
        wait_run_bit(1, 5);
        enable_i = 1'b0;
        step(15);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
